// File: rtl/nes_clk_pkg.sv
// Shared types and constants for the NES master-clock sequencer.
package nes_clk_pkg;
  typedef enum logic [1:0] {ST_PAUSED, ST_RUN, ST_DRAIN, ST_STEP} nes_state_e;

  localparam int NES_CPU_DIV = 12;
  localparam int NES_PPU_DIV = 4;
  localparam int PHASE_W     = 4;
endpackage

// File: rtl/nes_ce_gen.sv
// Master phase counter with registered cpu/ppu/apu enable decode.
// NES_APU_CE_EN adds the apu_ce divide-by-two toggle; otherwise apu_ce is 0.
module nes_ce_gen
  import nes_clk_pkg::*;
#(
  parameter int CPU_DIV   = NES_CPU_DIV,
  parameter int PPU_DIV   = NES_PPU_DIV,
  parameter int PPU_PHASE = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               advance,
  output logic [PHASE_W-1:0] phase,
  output logic               cpu_ce,
  output logic               ppu_ce,
  output logic               apu_ce
);
  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(CPU_DIV - 1);
  localparam logic [PHASE_W-1:0] PDIV = PHASE_W'(PPU_DIV);
  localparam logic [PHASE_W-1:0] POFF = PHASE_W'(PPU_PHASE);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic               cpu_ce_q, cpu_ce_d;
  logic               ppu_ce_q, ppu_ce_d;

  // Strobes decode the phase being left, so they land one cycle after it.
  always_comb begin
    phase_d  = phase_q;
    cpu_ce_d = 1'b0;
    ppu_ce_d = 1'b0;
    if (advance) begin
      phase_d  = (phase_q == LAST) ? '0 : phase_q + PHASE_W'(1);
      cpu_ce_d = (phase_q == LAST);
      ppu_ce_d = ((phase_q % PDIV) == POFF);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q  <= '0;
      cpu_ce_q <= 1'b0;
      ppu_ce_q <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      cpu_ce_q <= cpu_ce_d;
      ppu_ce_q <= ppu_ce_d;
    end
  end

`ifdef NES_APU_CE_EN
  logic apu_tog_q, apu_tog_d;
  logic apu_ce_q, apu_ce_d;

  // Toggle flips on each cpu_ce, so the first apu_ce rides the 2nd cpu_ce.
  always_comb begin
    apu_tog_d = apu_tog_q ^ cpu_ce_d;
    apu_ce_d  = cpu_ce_d & apu_tog_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      apu_tog_q <= 1'b0;
      apu_ce_q  <= 1'b0;
    end else begin
      apu_tog_q <= apu_tog_d;
      apu_ce_q  <= apu_ce_d;
    end
  end

  assign apu_ce = apu_ce_q;
`else
  assign apu_ce = 1'b0;
`endif

  assign phase  = phase_q;
  assign cpu_ce = cpu_ce_q;
  assign ppu_ce = ppu_ce_q;
endmodule

// File: rtl/nes_clock_sequencer.sv
// NES master-clock scheduler: run/pause/step FSM over nes_ce_gen, plus CPU cycle counter.
// Optional apu_ce generation is enabled with NES_APU_CE_EN.
module nes_clock_sequencer
  import nes_clk_pkg::*;
#(
  parameter int CPU_DIV   = NES_CPU_DIV,
  parameter int PPU_DIV   = NES_PPU_DIV,
  parameter int PPU_PHASE = 0,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run_req,
  input  logic               step_req,
  output logic               step_ack,
  output logic               paused,
  output logic               cpu_ce,
  output logic               ppu_ce,
  output logic               apu_ce,
  output logic [PHASE_W-1:0] phase,
  output logic [CNT_W-1:0]   cpu_cycle_cnt
);
  localparam logic [PHASE_W-1:0] LAST = PHASE_W'(CPU_DIV - 1);

  nes_state_e       state_q, state_d;
  logic             step_ack_q, step_ack_d;
  logic             paused_q, paused_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             advance;
  logic             at_zero, at_last;

  nes_ce_gen #(
    .CPU_DIV  (CPU_DIV),
    .PPU_DIV  (PPU_DIV),
    .PPU_PHASE(PPU_PHASE)
  ) u_ce_gen (
    .clk    (clk),
    .reset  (reset),
    .advance(advance),
    .phase  (phase),
    .cpu_ce (cpu_ce),
    .ppu_ce (ppu_ce),
    .apu_ce (apu_ce)
  );

  assign at_zero = (phase == '0);
  assign at_last = (phase == LAST);

  always_comb begin
    state_d = state_q;
    advance = 1'b0;
    case (state_q)
      ST_PAUSED: begin
        if (run_req)       state_d = ST_RUN;
        else if (step_req) state_d = ST_STEP;
      end
      ST_RUN: begin
        // Pausing on a boundary stops immediately; otherwise drain to the boundary.
        advance = run_req | ~at_zero;
        if (!run_req) state_d = at_zero ? ST_PAUSED : ST_DRAIN;
      end
      ST_DRAIN: begin
        advance = 1'b1;
        if (run_req)      state_d = ST_RUN;
        else if (at_last) state_d = ST_PAUSED;
      end
      ST_STEP: begin
        advance = 1'b1;
        if (at_last) state_d = run_req ? ST_RUN : ST_PAUSED;
      end
      default: state_d = ST_PAUSED;
    endcase
    step_ack_d = (state_q == ST_STEP) && at_last;
    paused_d   = (state_d == ST_PAUSED);
    cnt_d      = cnt_q + CNT_W'(cpu_ce);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_PAUSED;
      step_ack_q <= 1'b0;
      paused_q   <= 1'b1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      step_ack_q <= step_ack_d;
      paused_q   <= paused_d;
      cnt_q      <= cnt_d;
    end
  end

  assign step_ack      = step_ack_q;
  assign paused        = paused_q;
  assign cpu_cycle_cnt = cnt_q;
endmodule

// File: tb/tb_nes_clock_sequencer.sv
// Self-checking bench for nes_clock_sequencer: directed scenarios plus random run/step/reset traffic.
module tb_nes_clock_sequencer;
  localparam int CPU_DIV   = 12;
  localparam int PPU_DIV   = 4;
  localparam int PPU_PHASE = 2;
  localparam int CNT_W     = 4;
`ifdef NES_APU_CE_EN
  localparam bit APU_EN = 1'b1;
`else
  localparam bit APU_EN = 1'b0;
`endif

  localparam int M_PAUSED = 0, M_RUN = 1, M_DRAIN = 2, M_STEP = 3;

  logic             clk = 1'b0;
  logic             reset, run_req, step_req;
  logic             step_ack, paused, cpu_ce, ppu_ce, apu_ce;
  logic [3:0]       phase;
  logic [CNT_W-1:0] cpu_cycle_cnt;

  int vectors = 0, miscompares = 0;

  // Reference model state
  int m_mode, m_phase, m_cnt, m_ncpu;
  bit m_cpu, m_ppu, m_apu, m_ack;

  int tcount = 0;
  bit rec = 0;
  int cpu_ts[$];
  bit saw_wrap = 0;
  int prev_cnt = 0;

  nes_clock_sequencer #(
    .CPU_DIV(CPU_DIV), .PPU_DIV(PPU_DIV), .PPU_PHASE(PPU_PHASE), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .run_req(run_req), .step_req(step_req),
    .step_ack(step_ack), .paused(paused), .cpu_ce(cpu_ce), .ppu_ce(ppu_ce),
    .apu_ce(apu_ce), .phase(phase), .cpu_cycle_cnt(cpu_cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // One master cycle of the behavioural model, evaluated on the inputs seen at the edge.
  task automatic model_step();
    bit adv, lastp;
    if (reset) begin
      m_mode = M_PAUSED; m_phase = 0; m_cnt = 0; m_ncpu = 0;
      m_cpu = 0; m_ppu = 0; m_apu = 0; m_ack = 0;
      return;
    end
    adv   = (m_mode == M_RUN && (run_req || m_phase != 0)) || m_mode == M_DRAIN || m_mode == M_STEP;
    lastp = (m_phase == CPU_DIV - 1);
    m_cnt = (m_cnt + int'(m_cpu)) % (1 << CNT_W);
    m_ack = (m_mode == M_STEP) && lastp;
    m_cpu = adv && lastp;
    m_ppu = adv && (m_phase % PPU_DIV == PPU_PHASE);
    if (m_cpu) m_ncpu++;
    m_apu = APU_EN && m_cpu && (m_ncpu % 2 == 0);
    case (m_mode)
      M_PAUSED: if (run_req) m_mode = M_RUN; else if (step_req) m_mode = M_STEP;
      M_RUN:    if (!run_req) m_mode = (m_phase == 0) ? M_PAUSED : M_DRAIN;
      M_DRAIN:  if (run_req) m_mode = M_RUN; else if (lastp) m_mode = M_PAUSED;
      default:  if (lastp) m_mode = run_req ? M_RUN : M_PAUSED;
    endcase
    if (adv) m_phase = (m_phase + 1) % CPU_DIV;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    tcount++;
    if (rec && cpu_ce) cpu_ts.push_back(tcount);
    if (prev_cnt == (1 << CNT_W) - 1 && int'(cpu_cycle_cnt) == 0) saw_wrap = 1;
    prev_cnt = int'(cpu_cycle_cnt);
    chk("phase",    32'(phase),         32'(m_phase));
    chk("paused",   32'(paused),        32'(m_mode == M_PAUSED));
    chk("cpu_ce",   32'(cpu_ce),        32'(m_cpu));
    chk("ppu_ce",   32'(ppu_ce),        32'(m_ppu));
    chk("apu_ce",   32'(apu_ce),        32'(m_apu));
    chk("step_ack", 32'(step_ack),      32'(m_ack));
    chk("cpu_cnt",  32'(cpu_cycle_cnt), 32'(m_cnt));
  endtask

  task automatic wait_phase(input int p, input string tag);
    bit hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      tick();
      hit = (int'(phase) == p);
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  task automatic wait_paused(input string tag);
    bit hit = 0;
    for (int k = 0; k < 40 && !hit; k++) begin
      tick();
      hit = paused;
    end
    chk(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    int n, ncpu, nppu, napu, cnt0;
    bit done;
    reset = 1'b1; run_req = 1'b0; step_req = 1'b0;
    repeat (3) tick();
    chk("rst_paused", 32'(paused), 32'd1);
    chk("rst_phase",  32'(phase),  32'd0);
    reset = 1'b0;
    tick();

    // Free run: 120 advances hold 10 cpu_ce and 30 ppu_ce
    run_req = 1'b1;
    tick();
    ncpu = 0; nppu = 0;
    for (int i = 0; i < 120; i++) begin
      tick();
      ncpu += int'(cpu_ce);
      nppu += int'(ppu_ce);
    end
    chk("run_cpu_n", 32'(ncpu), 32'd10);
    chk("run_ppu_n", 32'(nppu), 32'd30);

    // Drop run at phase 5: 7 more advances then pause at phase 0
    wait_phase(5, "reach_ph5");
    run_req = 1'b0;
    n = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick(); n++; done = paused;
    end
    chk("drain_len",   32'(n),     32'd7);
    chk("drain_phase", 32'(phase), 32'd0);
    tick();
    cnt0 = int'(cpu_cycle_cnt);
    ncpu = 0; nppu = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      ncpu += int'(cpu_ce) + int'(ppu_ce);
    end
    chk("pause_no_strobe", 32'(ncpu), 32'd0);
    chk("pause_cnt_hold",  32'(cpu_cycle_cnt), 32'(cnt0));

    // Single step with an ignored second request mid-step
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    n = 0; ncpu = 0; nppu = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      step_req = (i == 4);
      tick(); n++;
      ncpu += int'(cpu_ce);
      nppu += int'(ppu_ce);
      done = step_ack;
    end
    step_req = 1'b0;
    chk("step_len",    32'(n),      32'd12);
    chk("step_cpu_n",  32'(ncpu),   32'd1);
    chk("step_ppu_n",  32'(nppu),   32'd3);
    chk("step_paused", 32'(paused), 32'd1);
    chk("step_phase",  32'(phase),  32'd0);
    repeat (15) tick();
    chk("step_no_requeue", 32'(paused), 32'd1);

    // Cancel a drain: cpu_ce cadence must stay unbroken at 12
    rec = 1; cpu_ts.delete();
    run_req = 1'b1;
    wait_phase(3, "reach_ph3");
    run_req = 1'b0;
    wait_phase(7, "reach_ph7");
    run_req = 1'b1;
    repeat (60) tick();
    rec = 0;
    chk("cadence_n_ok", 32'(cpu_ts.size() >= 5), 32'd1);
    for (int i = 1; i < cpu_ts.size(); i++)
      chk("cadence_gap", 32'(cpu_ts[i] - cpu_ts[i-1]), 32'(CPU_DIV));

    // Reset six cycles into a step aborts it without step_ack
    run_req = 1'b0;
    wait_paused("reach_pause");
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    repeat (6) tick();
    reset = 1'b1;
    tick();
    chk("rst_step_phase",  32'(phase),         32'd0);
    chk("rst_step_paused", 32'(paused),        32'd1);
    chk("rst_step_ack",    32'(step_ack),      32'd0);
    chk("rst_step_cnt",    32'(cpu_cycle_cnt), 32'd0);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      tick(); n += int'(step_ack);
    end
    chk("rst_no_late_ack", 32'(n), 32'd0);

    // Long run from reset: counter wraps and apu_ce rides every second cpu_ce
    run_req = 1'b1;
    ncpu = 0; napu = 0;
    for (int i = 0; i < 230; i++) begin
      tick();
      ncpu += int'(cpu_ce);
      napu += int'(apu_ce);
    end
    chk("cnt_wrap_seen", 32'(saw_wrap), 32'd1);
    chk("apu_count", 32'(napu), APU_EN ? 32'(ncpu / 2) : 32'd0);

    // Random run/step/reset traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(15) == 0) run_req = ~run_req;
      step_req = ($urandom_range(7) == 0);
      reset    = ($urandom_range(299) == 0);
      tick();
    end
    reset = 1'b0; run_req = 1'b0; step_req = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
